// File: rtl/xadc_wiz_pkg.sv
// Shared constants and types for the XADC behavioural model: channel numbers,
// DRP register addresses and the three-entry sequence index.
package xadc_wiz_pkg;

    localparam int CODE_W = 12;

    localparam logic [4:0] CH_VPVN   = 5'd3;
    localparam logic [4:0] CH_VAUX6  = 5'd22;
    localparam logic [4:0] CH_VAUX14 = 5'd30;

    localparam logic [6:0] ADDR_VPVN   = 7'h03;
    localparam logic [6:0] ADDR_VAUX6  = 7'h16;
    localparam logic [6:0] ADDR_VAUX14 = 7'h1E;
    localparam logic [6:0] ADDR_CFG0   = 7'h40;
    localparam logic [6:0] ADDR_CFG1   = 7'h41;
    localparam logic [6:0] ADDR_CFG2   = 7'h42;

    typedef logic [1:0] seq_idx_t;
    localparam seq_idx_t SEQ_LAST = 2'd2;

    function automatic logic [4:0] seq_channel(input seq_idx_t idx);
        case (idx)
            2'd0:    return CH_VPVN;
            2'd1:    return CH_VAUX6;
            default: return CH_VAUX14;
        endcase
    endfunction

endpackage

// File: rtl/xadc_wiz_if.sv
// DRP register port bundle; master drives requests, slave answers one cycle later.
// No backpressure: a new request may coincide with the previous drdy_out.
interface xadc_wiz_if;
    logic [6:0]  daddr_in;
    logic        den_in;
    logic        dwe_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;

    modport master (output daddr_in, den_in, dwe_in, di_in, input do_out, drdy_out);
    modport slave  (input daddr_in, den_in, dwe_in, di_in, output do_out, drdy_out);
endinterface

// File: rtl/xadc_wiz_drp_regfile.sv
// Status/config storage with DRP decode; drdy_out one cycle after den_in, reads see
// this cycle's updates. No backpressure: every request is answered.
module xadc_drp_regfile
    import xadc_wiz_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              upd_vld_i,
    input  seq_idx_t          upd_idx_i,
    input  logic [CODE_W-1:0] upd_code_i,
    xadc_wiz_if.slave         drp
);

    logic [2:0][15:0] stat_q, stat_d;
    logic [2:0][15:0] cfg_q, cfg_d;
    logic [15:0]      do_q, do_d;
    logic             drdy_q, drdy_d;
    logic [15:0]      rd_dat;

    always_comb begin
        stat_d = stat_q;
        cfg_d  = cfg_q;
        if (upd_vld_i) begin
            case (upd_idx_i)
                2'd0:    stat_d[0] = {upd_code_i, 4'h0};
                2'd1:    stat_d[1] = {upd_code_i, 4'h0};
                default: stat_d[2] = {upd_code_i, 4'h0};
            endcase
        end
        // Writes to status or unmapped addresses fall through and are dropped.
        if (drp.den_in && drp.dwe_in) begin
            case (drp.daddr_in)
                ADDR_CFG0: cfg_d[0] = drp.di_in;
                ADDR_CFG1: cfg_d[1] = drp.di_in;
                ADDR_CFG2: cfg_d[2] = drp.di_in;
                default:   ;
            endcase
        end
    end

    // Read from next-state so a read landing on the update edge sees the new code.
    always_comb begin
        rd_dat = 16'h0000;
        case (drp.daddr_in)
            ADDR_VPVN:   rd_dat = stat_d[0];
            ADDR_VAUX6:  rd_dat = stat_d[1];
            ADDR_VAUX14: rd_dat = stat_d[2];
            ADDR_CFG0:   rd_dat = cfg_d[0];
            ADDR_CFG1:   rd_dat = cfg_d[1];
            ADDR_CFG2:   rd_dat = cfg_d[2];
            default:     rd_dat = 16'h0000;
        endcase
    end

    always_comb begin
        drdy_d = drp.den_in;
        do_d   = do_q;
        if (drp.den_in && !drp.dwe_in) begin
            do_d = rd_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
            cfg_q  <= '0;
            do_q   <= '0;
            drdy_q <= 1'b0;
        end else begin
            stat_q <= stat_d;
            cfg_q  <= cfg_d;
            do_q   <= do_d;
            drdy_q <= drdy_d;
        end
    end

    assign drp.do_out   = do_q;
    assign drp.drdy_out = drdy_q;

endmodule

// File: rtl/xadc_wiz.sv
// Three-channel density-measurement ADC model: 2^CONV_LOG2 window cycles + 1 update
// cycle per channel, eoc_out/eos_out one cycle after the update. No backpressure.
module xadc_wiz
    import xadc_wiz_pkg::*;
#(
    parameter int CONV_LOG2 = 6
) (
    input  logic       dclk_in,
    input  logic       reset_in,
    xadc_wiz_if.slave  drp,
    input  logic       vp_in,
    input  logic       vn_in,
    input  logic       vauxp6,
    input  logic       vauxn6,
    input  logic       vauxp14,
    input  logic       vauxn14,
    output logic       busy_out,
    output logic       eoc_out,
    output logic       eos_out,
    output logic [4:0] channel_out,
    output logic       alarm_out
);

    localparam int CNT_W = CONV_LOG2 + 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [12:0]       acc_q, acc_d;
    seq_idx_t          idx_q, idx_d;
    logic              eoc_q, eoc_d;
    logic              eos_q, eos_d;
    logic [4:0]        ch_q, ch_d;
    logic              in_upd;
    logic              smp;
    logic [12:0]       scaled;
    logic [CODE_W-1:0] code;

    // The counter reaches exactly 2^CONV_LOG2 only in the update cycle.
    assign in_upd = cnt_q[CONV_LOG2];

    always_comb begin
        case (idx_q)
            2'd0:    smp = vp_in & ~vn_in;
            2'd1:    smp = vauxp6 & ~vauxn6;
            default: smp = vauxp14 & ~vauxn14;
        endcase
    end

    // A full-scale window scales to 4096, which saturates to the top code.
    assign scaled = acc_q << (CODE_W - CONV_LOG2);
    assign code   = scaled[12] ? {CODE_W{1'b1}} : scaled[CODE_W-1:0];

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_q + {12'd0, smp};
        idx_d = idx_q;
        eoc_d = 1'b0;
        eos_d = 1'b0;
        ch_d  = ch_q;
        if (in_upd) begin
            cnt_d = '0;
            acc_d = '0;
            idx_d = (idx_q == SEQ_LAST) ? 2'd0 : idx_q + 2'd1;
            eoc_d = 1'b1;
            eos_d = (idx_q == SEQ_LAST);
            ch_d  = seq_channel(idx_q);
        end
    end

    always_ff @(posedge dclk_in) begin
        if (reset_in) begin
            cnt_q <= '0;
            acc_q <= '0;
            idx_q <= '0;
            eoc_q <= 1'b0;
            eos_q <= 1'b0;
            ch_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            eoc_q <= eoc_d;
            eos_q <= eos_d;
            ch_q  <= ch_d;
        end
    end

    xadc_drp_regfile u_regfile (
        .clk_i      (dclk_in),
        .rst_i      (reset_in),
        .upd_vld_i  (in_upd),
        .upd_idx_i  (idx_q),
        .upd_code_i (code),
        .drp        (drp)
    );

    assign busy_out    = ~reset_in & ~in_upd;
    assign eoc_out     = eoc_q;
    assign eos_out     = eos_q;
    assign channel_out = ch_q;
    assign alarm_out   = 1'b0;

endmodule

// File: tb/tb_xadc_wiz.sv
// Bench for xadc_wiz: directed steps plus random traffic against a slot-arithmetic
// model of the conversion sequence and DRP register map.
module tb_xadc_wiz;

    logic        dclk_in = 1'b0;
    logic        reset_in;
    logic        vp_in, vn_in, vauxp6, vauxn6, vauxp14, vauxn14;
    logic        busy_out, eoc_out, eos_out, alarm_out;
    logic [4:0]  channel_out;

    xadc_wiz_if drp ();

    xadc_wiz #(.CONV_LOG2(6)) dut (
        .dclk_in     (dclk_in),
        .reset_in    (reset_in),
        .drp         (drp),
        .vp_in       (vp_in),
        .vn_in       (vn_in),
        .vauxp6      (vauxp6),
        .vauxn6      (vauxn6),
        .vauxp14     (vauxp14),
        .vauxn14     (vauxn14),
        .busy_out    (busy_out),
        .eoc_out     (eoc_out),
        .eos_out     (eos_out),
        .channel_out (channel_out),
        .alarm_out   (alarm_out)
    );

    always #5 dclk_in = ~dclk_in;

    localparam int WIN  = 64;
    localparam int SLOT = 65;

    int errors = 0;
    int checks = 0;

    // Model: cycle count since reset release decides slot and position.
    int          cyc;
    int          ones;
    logic [15:0] m_stat [3];
    logic [15:0] m_cfg  [3];
    logic        exp_eoc, exp_eos, exp_busy, exp_drdy;
    logic [4:0]  exp_ch;
    logic [15:0] exp_do;
    int          chan_of [3] = '{3, 22, 30};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [6:0] a);
        case (a)
            7'h03:   return m_stat[0];
            7'h16:   return m_stat[1];
            7'h1E:   return m_stat[2];
            7'h40:   return m_cfg[0];
            7'h41:   return m_cfg[1];
            7'h42:   return m_cfg[2];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        int pos, idx, v;
        logic b;
        if (reset_in) begin
            cyc = 0;
            ones = 0;
            for (int i = 0; i < 3; i++) begin
                m_stat[i] = '0;
                m_cfg[i]  = '0;
            end
            exp_eoc = 0; exp_eos = 0; exp_busy = 0; exp_drdy = 0;
            exp_ch = '0; exp_do = '0;
        end else begin
            pos = cyc % SLOT;
            idx = (cyc / SLOT) % 3;
            case (idx)
                0:       b = vp_in & ~vn_in;
                1:       b = vauxp6 & ~vauxn6;
                default: b = vauxp14 & ~vauxn14;
            endcase
            if (pos < WIN) begin
                ones += int'(b);
            end else begin
                v = ones * (4096 / WIN);
                if (v > 4095) v = 4095;
                m_stat[idx] = 16'(v * 16);
                ones = 0;
            end
            if (drp.den_in && drp.dwe_in) begin
                if (drp.daddr_in >= 7'h40 && drp.daddr_in <= 7'h42)
                    m_cfg[drp.daddr_in - 7'h40] = drp.di_in;
            end else if (drp.den_in) begin
                exp_do = m_read(drp.daddr_in);
            end
            exp_drdy = drp.den_in;
            exp_eoc  = (pos == WIN);
            exp_eos  = (pos == WIN) && (idx == 2);
            if (pos == WIN) exp_ch = 5'(chan_of[idx]);
            exp_busy = ((cyc + 1) % SLOT) < WIN;
            cyc++;
        end
        @(posedge dclk_in);
        #1;
        check("eoc_out", 16'(eoc_out), 16'(exp_eoc));
        check("eos_out", 16'(eos_out), 16'(exp_eos));
        check("channel_out", 16'(channel_out), 16'(exp_ch));
        check("busy_out", 16'(busy_out), 16'(exp_busy));
        check("drdy_out", 16'(drdy_out_w()), 16'(exp_drdy));
        check("do_out", drp.do_out, exp_do);
        check("alarm_out", 16'(alarm_out), 16'h0000);
    endtask

    function automatic logic drdy_out_w();
        return drp.drdy_out;
    endfunction

    task automatic drp_op(input logic [6:0] a, input logic we, input logic [15:0] d);
        drp.den_in   = 1'b1;
        drp.dwe_in   = we;
        drp.daddr_in = a;
        drp.di_in    = d;
        tick();
        drp.den_in = 1'b0;
        drp.dwe_in = 1'b0;
    endtask

    initial begin
        int n, last_eos;
        logic [15:0] held;
        int thr6, thr14, thrvp;
        logic [6:0] addr_tab [8] = '{7'h03, 7'h16, 7'h1E, 7'h40, 7'h41, 7'h42, 7'h7F, 7'h00};

        vp_in = 0; vn_in = 0; vauxp6 = 0; vauxn6 = 0; vauxp14 = 0; vauxn14 = 0;
        drp.daddr_in = 7'h40; drp.dwe_in = 1'b1; drp.di_in = 16'hFFFF; drp.den_in = 1'b1;

        // Reset held 3 cycles with a stray write that must be dropped.
        reset_in = 1'b1;
        repeat (3) tick();
        drp.den_in = 1'b0; drp.dwe_in = 1'b0;
        reset_in = 1'b0;
        #1;
        check("busy_after_release", 16'(busy_out), 16'h0001);

        // Full scale on VAUX6, zero on VAUX14; first eoc 65 cycles in.
        vauxp6 = 1; vauxn6 = 0; vauxp14 = 0; vauxn14 = 0;
        n = 0;
        while (!eoc_out && n < 100) begin
            tick();
            n++;
        end
        check("first_eoc_cycle", 16'(n), 16'd65);
        check("first_eoc_channel", 16'(channel_out), 16'd3);

        drp.daddr_in = 7'h16; drp.dwe_in = 1'b0;
        repeat (200) begin
            drp.den_in = exp_eoc;
            tick();
        end
        drp.den_in = 1'b0;
        drp_op(7'h16, 1'b0, 16'h0);
        check("full_scale_0x16", drp.do_out, 16'hFFF0);
        drp_op(7'h1E, 1'b0, 16'h0);
        check("zero_scale_0x1E", drp.do_out, 16'h0000);
        drp_op(7'h40, 1'b0, 16'h0);
        check("reset_dropped_write", drp.do_out, 16'h0000);

        // Half density on VAUX14.
        repeat (200) begin
            vauxp14 = ~vauxp14;
            tick();
        end
        vauxp14 = 0;
        drp_op(7'h1E, 1'b0, 16'h0);
        check("half_density_0x1E", drp.do_out, 16'h8000);

        // Differential cancel on VAUX6; eos spacing.
        vauxp6 = 1; vauxn6 = 1;
        last_eos = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (eos_out) begin
                check("eos_with_eoc", 16'(eoc_out), 16'h0001);
                check("eos_channel", 16'(channel_out), 16'd30);
                if (last_eos >= 0) check("eos_spacing", 16'(cyc - last_eos), 16'd195);
                last_eos = cyc;
            end
        end
        check("eos_seen", 16'(last_eos >= 0), 16'h0001);
        drp_op(7'h16, 1'b0, 16'h0);
        check("cancel_0x16", drp.do_out, 16'h0000);

        // Config registers; the read is issued in the write's drdy cycle.
        held = exp_do;
        drp_op(7'h41, 1'b1, 16'h1234);
        check("wr_drdy", 16'(drp.drdy_out), 16'h0001);
        check("wr_do_held", drp.do_out, held);
        drp_op(7'h41, 1'b0, 16'h0);
        check("cfg1_readback", drp.do_out, 16'h1234);
        drp_op(7'h16, 1'b1, 16'hBEEF);
        drp_op(7'h16, 1'b0, 16'h0);
        check("status_write_ignored", drp.do_out, 16'h0000);
        drp_op(7'h7F, 1'b0, 16'h0);
        check("unmapped_0x7F", drp.do_out, 16'h0000);

        // Random traffic with per-segment densities.
        thr6 = 0; thr14 = 0; thrvp = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                thr6  = $urandom_range(0, 8);
                thr14 = $urandom_range(0, 8);
                thrvp = $urandom_range(0, 8);
            end
            vp_in   = ($urandom % 8) < thrvp;
            vn_in   = ($urandom % 4) == 0;
            vauxp6  = ($urandom % 8) < thr6;
            vauxn6  = ($urandom % 6) == 0;
            vauxp14 = ($urandom % 8) < thr14;
            vauxn14 = ($urandom % 5) == 0;
            drp.den_in   = ($urandom % 4) == 0;
            drp.dwe_in   = ($urandom % 3) == 0;
            drp.daddr_in = addr_tab[$urandom % 8];
            drp.di_in    = 16'($urandom);
            tick();
        end
        drp.den_in = 1'b0; drp.dwe_in = 1'b0;
        vp_in = 1; vn_in = 0; vauxp6 = 1; vauxn6 = 0;

        // Reset pulse at window cycle 40.
        n = 0;
        while ((cyc % SLOT) != 40 && n < 200) begin
            tick();
            n++;
        end
        check("reach_window_40", 16'(cyc % SLOT), 16'd40);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        #1;
        check("busy_after_pulse", 16'(busy_out), 16'h0001);
        drp_op(7'h16, 1'b0, 16'h0);
        check("post_reset_0x16", drp.do_out, 16'h0000);
        n = 1;
        while (!eoc_out && n < 100) begin
            tick();
            n++;
        end
        check("eoc_after_pulse_cycle", 16'(n), 16'd65);
        check("eoc_after_pulse_channel", 16'(channel_out), 16'd3);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xadc_wiz.md
# xadc_wiz

Synthesizable behavioural model of the XADC wizard block used by the motor current sensor. It sequences continuously through three analog channels (VP/VN, VAUX6, VAUX14), converts each 1-bit differential pin pair into a 12-bit code by density measurement, and exposes the results through a DRP-style register read/write port. End-of-conversion and end-of-sequence strobes let the consumer tie `eoc_out` straight to `den_in`.

## Interface
- `CONV_LOG2`, default 6: conversion window is 2^CONV_LOG2 clock cycles. Legal range is 1..12.
- `dclk_in`  in  1: the only clock, rising edge.
- `reset_in`  in  1: synchronous, active-high reset.
- `daddr_in`  in  7: DRP register address, sampled when `den_in`=1.
- `den_in`  in  1: DRP enable strobe.
- `dwe_in`  in  1: DRP write enable, qualified by `den_in`.
- `di_in`  in  16: DRP write data.
- `vp_in`, `vn_in`  in  1 each: dedicated pair, channel 3.
- `vauxp6`, `vauxn6`  in  1 each: aux pair, channel 22 (0x16).
- `vauxp14`, `vauxn14`  in  1 each: aux pair, channel 30 (0x1E).
- `do_out`  out  16: DRP read data.
- `drdy_out`  out  1: DRP done pulse.
- `busy_out`  out  1: conversion window in progress.
- `eoc_out`  out  1: end-of-conversion pulse.
- `eos_out`  out  1: end-of-sequence pulse.
- `channel_out`  out  5: channel of the last completed conversion.
- `alarm_out`  out  1: fixed at 0. No on-chip sensors are modelled.

## Operation
- **Sequence order:** 3 → 22 → 30 → 3 …, repeating forever after reset.
- **Sampling:** each cycle of a window samples `p & ~n` of the current pair. A 13-bit counter accumulates the ones.
- **Code:** `code = min(ones << (12-CONV_LOG2), 4095)`.
- **Status registers:** the code is stored left-justified (`code<<4`, low nibble 0) at address 0x03, 0x16 or 0x1E according to channel.
- **Config registers:** 0x40, 0x41 and 0x42 are 16-bit read/write.
- **Other addresses:** reads of any other address return 0x0000. Writes to status or unmapped addresses are acknowledged and ignored.
- **DRP read:** `den_in`=1 with `dwe_in`=0 latches `daddr_in`.
- **DRP write:** `den_in`=1 with `dwe_in`=1 writes `di_in` to the config register. `do_out` is unchanged on a write.
- **DRP collision:** only one DRP transaction may be outstanding. A `den_in` arriving in the same cycle that `drdy_out`=1 is accepted normally. No other overlap is possible, given the 1-cycle latency.
- **Reset:**
  - All registers clear to 0 and the sequence restarts at channel 3, counter 0.
  - `do_out`=0, `drdy_out`=0, `eoc_out`=0, `eos_out`=0, `channel_out`=0, `busy_out`=0.
  - A DRP request in the reset cycle is dropped.

## Timing
- **Conversion slot:** 2^CONV_LOG2 window cycles (`busy_out`=1), then 1 update cycle (`busy_out`=0). Default is 65 cycles per channel and 195 per sequence.
- **First window:** starts in the first cycle after reset deasserts.
- **Result update:** the result register is written at the clock edge ending the update cycle.
- **Strobes:** `eoc_out` is high for exactly the following cycle, with `channel_out` updated on the same edge. That cycle is also window cycle 0 of the next channel.
- **End of sequence:** `eos_out` is high in the same cycle as the `eoc_out` for channel 30 only.
- **DRP latency:**
  - `den_in` in cycle T gives `drdy_out`=1 for exactly cycle T+1.
  - On a read, `do_out` carries `reg[addr]` as it stands after the edge ending T.
  - `do_out` then holds until the next read completes.
- **Same-cycle read and update:** a read whose `den_in` coincides with `eoc_out` returns the freshly written value.
- **Write timing:** a write is visible to a read issued in T+1.
- **Reset mid-window:** the partial accumulation is discarded and no `eoc_out` is issued.

## Structure
- Shared package holds:
  - channel and address constants: `CH_VPVN`=3, `CH_VAUX6`=22, `CH_VAUX14`=30, `ADDR_CFG0..2`=0x40..0x42;
  - code width 12;
  - a sequence-index type (0..2).
- One natural sub-module, `xadc_drp_regfile`: the status and config storage, DRP decode, and the `drdy_out`/`do_out` pipeline.
- Sequencer and accumulator sit in the top level.

## Test plan
- **Reset values:** hold `reset_in` 3 cycles → all outputs 0. After release, the first `eoc_out` occurs at cycle 65 with `channel_out`=3.
- **Full and zero scale:** `vauxp6`=1, `vauxn6`=0, `vauxp14`=0 constant; `den_in`=`eoc_out`, `daddr_in`=0x16 → next cycle `drdy_out`=1, `do_out`=0xFFF0. Address 0x1E then reads 0x0000.
- **Half density:** toggle `vauxp14` every cycle, `vauxn14`=0 → 32 ones per 64-cycle window → 0x1E reads 0x8000.
- **Differential cancel:** `vauxp6`=`vauxn6`=1 → 0x16 reads 0x0000. `eos_out` coincides only with the `channel_out`=30 `eoc_out`, every 195 cycles.
- **Config registers:** write 0x1234 to 0x41 → `drdy_out` pulses and `do_out` is unchanged. Read 0x41 → 0x1234. Write to 0x16 → no effect. Read 0x7F → 0x0000.
- **Reset mid-window:** pulse `reset_in` at window cycle 40 → no `eoc_out` for that slot, and the 0x16 read returns 0. The next `eoc_out` arrives 65 cycles after release with `channel_out`=3.
